// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice.
//   - internal opcode ids (lui .. andd, 7'd1 .. 7'd37)
//   - RoB / register index widths
//   - NON_DEP: dependency tag meaning "operand value already valid"
//   - NON_REG: register tag meaning "no destination register"
package reservation_station_pkg;

  localparam int RoB_W    = 4;
  localparam int EX_RoB_W = RoB_W + 1;
  localparam int REG_W    = 5;

  localparam logic [EX_RoB_W-1:0] NON_DEP = EX_RoB_W'(1 << RoB_W);
  localparam logic [REG_W:0]      NON_REG = (REG_W+1)'(1 << REG_W);

  localparam logic [6:0] lui   = 7'd1;
  localparam logic [6:0] auipc = 7'd2;
  localparam logic [6:0] jal   = 7'd3;
  localparam logic [6:0] jalr  = 7'd4;
  localparam logic [6:0] beq   = 7'd5;
  localparam logic [6:0] bne   = 7'd6;
  localparam logic [6:0] blt   = 7'd7;
  localparam logic [6:0] bge   = 7'd8;
  localparam logic [6:0] bltu  = 7'd9;
  localparam logic [6:0] bgeu  = 7'd10;
  localparam logic [6:0] lb    = 7'd11;
  localparam logic [6:0] lh    = 7'd12;
  localparam logic [6:0] lw    = 7'd13;
  localparam logic [6:0] lbu   = 7'd14;
  localparam logic [6:0] lhu   = 7'd15;
  localparam logic [6:0] sb    = 7'd16;
  localparam logic [6:0] sh    = 7'd17;
  localparam logic [6:0] sw    = 7'd18;
  localparam logic [6:0] addi  = 7'd19;
  localparam logic [6:0] slti  = 7'd20;
  localparam logic [6:0] sltiu = 7'd21;
  localparam logic [6:0] xori  = 7'd22;
  localparam logic [6:0] ori   = 7'd23;
  localparam logic [6:0] andi  = 7'd24;
  localparam logic [6:0] slli  = 7'd25;
  localparam logic [6:0] srli  = 7'd26;
  localparam logic [6:0] srai  = 7'd27;
  localparam logic [6:0] add   = 7'd28;
  localparam logic [6:0] sub   = 7'd29;
  localparam logic [6:0] sll   = 7'd30;
  localparam logic [6:0] slt   = 7'd31;
  localparam logic [6:0] sltu  = 7'd32;
  localparam logic [6:0] xorr  = 7'd33;
  localparam logic [6:0] srl   = 7'd34;
  localparam logic [6:0] sra   = 7'd35;
  localparam logic [6:0] orr   = 7'd36;
  localparam logic [6:0] andd  = 7'd37;

endpackage

// File: rtl/rs_priority_sel.sv
// Lowest-index picker.
//   req   : request vector
//   gnt   : one-hot grant of the lowest set bit of req (zero if none)
//   idx   : binary index of that bit (zero if none)
//   found : any bit of req set
module rs_priority_sel #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the last (lowest) hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-load/store instructions.
// Accepts one dispatch per cycle, snoops the ALU and LSB result buses to
// resolve operand dependencies, and issues the lowest-index ready entry to
// the ALU each cycle.
//   Sys_clk / Sys_rst_n / Sys_rdy : clock, async active-low reset, enable
//   RoBRS_pre_judge               : 0 flushes every entry
//   DPRS_*                        : dispatch request; RSDP_full back-pressure
//   CDBRS_RS_* / CDBRS_LSB_*      : result broadcasts used for wakeup
//   RSALU_*                       : registered issue to the ALU
module reservation_station #(
  parameter int RS_WIDTH     = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int RoB_WIDTH    = 4,
  parameter int EX_RoB_WIDTH = 5,
  parameter int NON_DEP      = 1 << RoB_WIDTH
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic                    RoBRS_pre_judge,
  input  logic                    DPRS_en,
  input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
  input  logic [31:0]             DPRS_Vj,
  input  logic [31:0]             DPRS_Vk,
  input  logic [31:0]             DPRS_imm,
  input  logic [6:0]              DPRS_opcode,
  input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
  output logic                    RSDP_full,
  input  logic                    CDBRS_RS_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
  input  logic [31:0]             CDBRS_RS_value,
  input  logic                    CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
  input  logic [31:0]             CDBRS_LSB_value,
  output logic                    RSALU_en,
  output logic [6:0]              RSALU_opcode,
  output logic [ADDR_WIDTH-1:0]   RSALU_pc,
  output logic [31:0]             RSALU_Vj,
  output logic [31:0]             RSALU_Vk,
  output logic [31:0]             RSALU_imm,
  output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);
  import reservation_station_pkg::*;

  localparam int N = 1 << RS_WIDTH;
  localparam logic [EX_RoB_WIDTH-1:0] NDEP = EX_RoB_WIDTH'(NON_DEP);

  logic [N-1:0]            busy, busy_nxt, ready;
  logic [6:0]              op_q  [N];
  logic [ADDR_WIDTH-1:0]   pc_q  [N];
  logic [EX_RoB_WIDTH-1:0] qj_q  [N];
  logic [EX_RoB_WIDTH-1:0] qk_q  [N];
  logic [31:0]             vj_q  [N];
  logic [31:0]             vk_q  [N];
  logic [31:0]             imm_q [N];
  logic [RoB_WIDTH-1:0]    rob_q [N];

  logic [N-1:0]            free_gnt, rdy_gnt;
  logic [RS_WIDTH-1:0]     free_idx, rdy_idx;
  logic                    free_found, rdy_found, ins_en;
  logic [RS_WIDTH:0]       free_cnt;
  logic [EX_RoB_WIDTH-1:0] ins_qj, ins_qk;
  logic [31:0]             ins_vj, ins_vk;

  // A tag matches a bus only while it still names a real RoB entry.
  function automatic logic tag_hit(input logic [EX_RoB_WIDTH-1:0] q,
                                   input logic en,
                                   input logic [RoB_WIDTH-1:0] tag);
    return en && (q != NDEP) && (q == {1'b0, tag});
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++)
      ready[i] = busy[i] && (qj_q[i] == NDEP) && (qk_q[i] == NDEP);
  end

  rs_priority_sel #(.N(N), .IDX_W(RS_WIDTH)) u_free_sel (
    .req(~busy), .gnt(free_gnt), .idx(free_idx), .found(free_found)
  );

  rs_priority_sel #(.N(N), .IDX_W(RS_WIDTH)) u_rdy_sel (
    .req(ready), .gnt(rdy_gnt), .idx(rdy_idx), .found(rdy_found)
  );

  // Two free slots are needed: the dispatcher may already have one in flight.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N; i++)
      free_cnt = free_cnt + {{RS_WIDTH{1'b0}}, ~busy[i]};
  end
  assign RSDP_full = (free_cnt <= (RS_WIDTH+1)'(1));

  assign ins_en = DPRS_en && free_found;

  // Same-cycle bypass for the incoming instruction; the ALU bus wins ties.
  always_comb begin
    ins_qj = DPRS_Qj;
    ins_vj = DPRS_Vj;
    ins_qk = DPRS_Qk;
    ins_vk = DPRS_Vk;
    if (tag_hit(DPRS_Qj, CDBRS_RS_en, CDBRS_RS_RoB_index)) begin
      ins_qj = NDEP; ins_vj = CDBRS_RS_value;
    end else if (tag_hit(DPRS_Qj, CDBRS_LSB_en, CDBRS_LSB_RoB_index)) begin
      ins_qj = NDEP; ins_vj = CDBRS_LSB_value;
    end
    if (tag_hit(DPRS_Qk, CDBRS_RS_en, CDBRS_RS_RoB_index)) begin
      ins_qk = NDEP; ins_vk = CDBRS_RS_value;
    end else if (tag_hit(DPRS_Qk, CDBRS_LSB_en, CDBRS_LSB_RoB_index)) begin
      ins_qk = NDEP; ins_vk = CDBRS_LSB_value;
    end
  end

  // The insert slot is free in registered state, so it never collides with
  // the slot being issued.
  assign busy_nxt = (busy & ~rdy_gnt) | (ins_en ? free_gnt : '0);

  // ---- entry storage: insert or wakeup ----
  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy && RoBRS_pre_judge) begin
      for (int i = 0; i < N; i++) begin
        if (ins_en && (free_idx == RS_WIDTH'(i))) begin
          op_q[i]  <= DPRS_opcode;
          pc_q[i]  <= DPRS_pc;
          qj_q[i]  <= ins_qj;
          qk_q[i]  <= ins_qk;
          vj_q[i]  <= ins_vj;
          vk_q[i]  <= ins_vk;
          imm_q[i] <= DPRS_imm;
          rob_q[i] <= DPRS_RoB_index;
        end else begin
          if (tag_hit(qj_q[i], CDBRS_RS_en, CDBRS_RS_RoB_index)) begin
            qj_q[i] <= NDEP; vj_q[i] <= CDBRS_RS_value;
          end else if (tag_hit(qj_q[i], CDBRS_LSB_en, CDBRS_LSB_RoB_index)) begin
            qj_q[i] <= NDEP; vj_q[i] <= CDBRS_LSB_value;
          end
          if (tag_hit(qk_q[i], CDBRS_RS_en, CDBRS_RS_RoB_index)) begin
            qk_q[i] <= NDEP; vk_q[i] <= CDBRS_RS_value;
          end else if (tag_hit(qk_q[i], CDBRS_LSB_en, CDBRS_LSB_RoB_index)) begin
            qk_q[i] <= NDEP; vk_q[i] <= CDBRS_LSB_value;
          end
        end
      end
    end
  end

  // ---- occupancy and issue register ----
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      busy            <= '0;
      RSALU_en        <= 1'b0;
      RSALU_opcode    <= '0;
      RSALU_pc        <= '0;
      RSALU_Vj        <= '0;
      RSALU_Vk        <= '0;
      RSALU_imm       <= '0;
      RSALU_RoB_index <= '0;
    end else if (Sys_rdy) begin
      if (!RoBRS_pre_judge) begin
        busy            <= '0;
        RSALU_en        <= 1'b0;
        RSALU_opcode    <= '0;
        RSALU_pc        <= '0;
        RSALU_Vj        <= '0;
        RSALU_Vk        <= '0;
        RSALU_imm       <= '0;
        RSALU_RoB_index <= '0;
      end else begin
        busy     <= busy_nxt;
        RSALU_en <= rdy_found;
        if (rdy_found) begin
          RSALU_opcode    <= op_q[rdy_idx];
          RSALU_pc        <= pc_q[rdy_idx];
          RSALU_Vj        <= vj_q[rdy_idx];
          RSALU_Vk        <= vk_q[rdy_idx];
          RSALU_imm       <= imm_q[rdy_idx];
          RSALU_RoB_index <= rob_q[rdy_idx];
        end
      end
    end
  end

  dispatch_into_full: assert property (@(posedge Sys_clk) disable iff (!Sys_rst_n)
    !(Sys_rdy && RoBRS_pre_judge && DPRS_en && !free_found));

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n, Sys_rdy, RoBRS_pre_judge, DPRS_en;
  logic [31:0] DPRS_pc, DPRS_Vj, DPRS_Vk, DPRS_imm;
  logic [4:0]  DPRS_Qj, DPRS_Qk;
  logic [6:0]  DPRS_opcode;
  logic [3:0]  DPRS_RoB_index;
  logic        RSDP_full;
  logic        CDBRS_RS_en, CDBRS_LSB_en;
  logic [3:0]  CDBRS_RS_RoB_index, CDBRS_LSB_RoB_index;
  logic [31:0] CDBRS_RS_value, CDBRS_LSB_value;
  logic        RSALU_en;
  logic [6:0]  RSALU_opcode;
  logic [31:0] RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm;
  logic [3:0]  RSALU_RoB_index;

  reservation_station dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .RoBRS_pre_judge(RoBRS_pre_judge), .DPRS_en(DPRS_en), .DPRS_pc(DPRS_pc),
    .DPRS_Qj(DPRS_Qj), .DPRS_Qk(DPRS_Qk), .DPRS_Vj(DPRS_Vj), .DPRS_Vk(DPRS_Vk),
    .DPRS_imm(DPRS_imm), .DPRS_opcode(DPRS_opcode), .DPRS_RoB_index(DPRS_RoB_index),
    .RSDP_full(RSDP_full), .CDBRS_RS_en(CDBRS_RS_en),
    .CDBRS_RS_RoB_index(CDBRS_RS_RoB_index), .CDBRS_RS_value(CDBRS_RS_value),
    .CDBRS_LSB_en(CDBRS_LSB_en), .CDBRS_LSB_RoB_index(CDBRS_LSB_RoB_index),
    .CDBRS_LSB_value(CDBRS_LSB_value), .RSALU_en(RSALU_en),
    .RSALU_opcode(RSALU_opcode), .RSALU_pc(RSALU_pc), .RSALU_Vj(RSALU_Vj),
    .RSALU_Vk(RSALU_Vk), .RSALU_imm(RSALU_imm), .RSALU_RoB_index(RSALU_RoB_index)
  );

  initial forever #5 Sys_clk = ~Sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          busy;
    logic [6:0]  op;
    logic [31:0] pc, vj, vk, imm;
    logic [4:0]  qj, qk;
    logic [3:0]  rob;
  } ent_t;

  ent_t        m [8];
  logic        m_en;
  logic [6:0]  m_op;
  logic [31:0] m_pc, m_vj, m_vk, m_imm;
  logic [3:0]  m_rob;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i].busy = 0;
    m_en = 0; m_op = 0; m_pc = 0; m_vj = 0; m_vk = 0; m_imm = 0; m_rob = 0;
  endtask

  function automatic bit model_full();
    int nfree = 0;
    for (int i = 0; i < 8; i++) if (!m[i].busy) nfree++;
    return nfree <= 1;
  endfunction

  // Resolve one operand against the broadcasts visible this cycle.
  function automatic logic [36:0] resolve(input logic [4:0] q, input logic [31:0] v);
    if (q != 5'd16 && CDBRS_RS_en && q == {1'b0, CDBRS_RS_RoB_index})
      return {5'd16, CDBRS_RS_value};
    if (q != 5'd16 && CDBRS_LSB_en && q == {1'b0, CDBRS_LSB_RoB_index})
      return {5'd16, CDBRS_LSB_value};
    return {q, v};
  endfunction

  task automatic model_step();
    ent_t nx [8];
    int iss = -1;
    int ins = -1;
    if (!Sys_rst_n) begin model_reset(); return; end
    if (!Sys_rdy) return;
    if (!RoBRS_pre_judge) begin model_reset(); return; end
    for (int i = 0; i < 8; i++)
      if (iss < 0 && m[i].busy && m[i].qj == 5'd16 && m[i].qk == 5'd16) iss = i;
    for (int i = 0; i < 8; i++)
      if (ins < 0 && !m[i].busy) ins = i;
    nx = m;
    for (int i = 0; i < 8; i++) begin
      if (m[i].busy) begin
        {nx[i].qj, nx[i].vj} = resolve(m[i].qj, m[i].vj);
        {nx[i].qk, nx[i].vk} = resolve(m[i].qk, m[i].vk);
      end
    end
    if (iss >= 0) begin
      m_en = 1; m_op = m[iss].op; m_pc = m[iss].pc; m_vj = m[iss].vj;
      m_vk = m[iss].vk; m_imm = m[iss].imm; m_rob = m[iss].rob;
      nx[iss].busy = 0;
    end else begin
      m_en = 0;
    end
    if (DPRS_en && ins >= 0) begin
      nx[ins].busy = 1;
      nx[ins].op   = DPRS_opcode;
      nx[ins].pc   = DPRS_pc;
      nx[ins].imm  = DPRS_imm;
      nx[ins].rob  = DPRS_RoB_index;
      {nx[ins].qj, nx[ins].vj} = resolve(DPRS_Qj, DPRS_Vj);
      {nx[ins].qk, nx[ins].vk} = resolve(DPRS_Qk, DPRS_Vk);
    end
    m = nx;
  endtask

  task automatic compare_model();
    chk("model_en", RSALU_en, m_en);
    chk("model_full", RSDP_full, model_full());
    chk("model_fields", {RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index},
        {m_op, m_pc, m_vj, m_vk, m_imm, m_rob});
  endtask

  // Advance one clock: model consumes current inputs, DUT sampled 1 after edge.
  task automatic tick();
    model_step();
    @(posedge Sys_clk);
    #1;
    compare_model();
  endtask

  task automatic clr();
    DPRS_en = 0; CDBRS_RS_en = 0; CDBRS_LSB_en = 0;
    RoBRS_pre_judge = 1; Sys_rdy = 1;
  endtask

  task automatic dp(input logic [6:0] op, input logic [4:0] qj, input logic [4:0] qk,
                    input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] rob);
    DPRS_en = 1; DPRS_opcode = op; DPRS_Qj = qj; DPRS_Qk = qk;
    DPRS_Vj = vj; DPRS_Vk = vk; DPRS_RoB_index = rob;
    DPRS_pc = 32'h1000 + {28'd0, rob} * 4; DPRS_imm = {28'd0, rob} + 32'h100;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        d_en;
    logic [6:0]  op;
    logic [4:0]  qj, qk;
    logic [31:0] vj, vk;
    logic [3:0]  rob;
    logic        r_en; logic [3:0] r_tag; logic [31:0] r_val;
    logic        l_en; logic [3:0] l_tag; logic [31:0] l_val;
    logic        x_en; logic [31:0] x_vj, x_vk; logic [3:0] x_rob; logic x_full;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 7'd28, 5'd16, 5'd16, 32'd5, 32'd7, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0,    32'd0,    4'd0, 1'b0};
    tbl[1] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5,    32'd7,    4'd3, 1'b0};
    tbl[2] = '{1'b1, 7'd29, 5'd2,  5'd16, 32'd0, 32'd9, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd5,    32'd7,    4'd3, 1'b0};
    tbl[3] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd5,    32'd7,    4'd3, 1'b0};
    tbl[4] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b1, 4'd2, 32'h10, 1'b0, 4'd0, 32'd0, 1'b0, 32'd5,   32'd7,    4'd3, 1'b0};
    tbl[5] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h10,   32'd9,    4'd4, 1'b0};
    tbl[6] = '{1'b1, 7'd30, 5'd16, 5'd4,  32'd1, 32'd0, 4'd5, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hAB, 1'b0, 32'h10,  32'd9,    4'd4, 1'b0};
    tbl[7] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd1,    32'hAB,   4'd5, 1'b0};
    tbl[8] = '{1'b0, 7'd0,  5'd16, 5'd16, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd1,    32'hAB,   4'd5, 1'b0};
  end

  initial begin
    Sys_rst_n = 0; clr();
    dp(7'd0, 5'd16, 5'd16, 0, 0, 0); DPRS_en = 0;
    CDBRS_RS_RoB_index = 0; CDBRS_RS_value = 0;
    CDBRS_LSB_RoB_index = 0; CDBRS_LSB_value = 0;
    model_reset();
    repeat (2) @(posedge Sys_clk);
    #1;
    chk("reset_en", RSALU_en, 1'b0);
    chk("reset_full", RSDP_full, 1'b0);
    chk("reset_fields", {RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index}, '0);
    Sys_rst_n = 1;

    // Table: ready dispatch, RS-bus wakeup, LSB bypass at insert.
    for (int r = 0; r < 9; r++) begin
      clr();
      if (tbl[r].d_en) dp(tbl[r].op, tbl[r].qj, tbl[r].qk, tbl[r].vj, tbl[r].vk, tbl[r].rob);
      CDBRS_RS_en = tbl[r].r_en; CDBRS_RS_RoB_index = tbl[r].r_tag; CDBRS_RS_value = tbl[r].r_val;
      CDBRS_LSB_en = tbl[r].l_en; CDBRS_LSB_RoB_index = tbl[r].l_tag; CDBRS_LSB_value = tbl[r].l_val;
      tick();
      chk($sformatf("tbl%0d_en", r), RSALU_en, tbl[r].x_en);
      chk($sformatf("tbl%0d_vj", r), RSALU_Vj, tbl[r].x_vj);
      chk($sformatf("tbl%0d_vk", r), RSALU_Vk, tbl[r].x_vk);
      chk($sformatf("tbl%0d_rob", r), RSALU_RoB_index, tbl[r].x_rob);
      chk($sformatf("tbl%0d_full", r), RSDP_full, tbl[r].x_full);
    end
    clr();

    // Fill 7 entries waiting on tag 9, then wake all and drain in order.
    for (int i = 0; i < 7; i++) begin
      dp(7'd28, 5'd9, 5'd16, 0, 32'd100 + i, 4'(i));
      tick(); clr();
      chk($sformatf("fill%0d_full", i), RSDP_full, (i == 6));
    end
    CDBRS_RS_en = 1; CDBRS_RS_RoB_index = 4'd9; CDBRS_RS_value = 32'h900;
    tick(); clr();
    chk("wake_no_issue", RSALU_en, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("drain%0d_en", i), RSALU_en, 1'b1);
      chk($sformatf("drain%0d_rob", i), RSALU_RoB_index, 4'(i));
      chk($sformatf("drain%0d_vj", i), RSALU_Vj, 32'h900);
      if (i == 0) chk("full_drop", RSDP_full, 1'b0);
    end
    tick();
    chk("drained_idle", RSALU_en, 1'b0);

    // Entries 1 and 5 become ready together; the rest keep waiting.
    for (int i = 0; i < 6; i++) begin
      dp(7'd31, (i == 1 || i == 5) ? 5'd7 : 5'd12, 5'd16, 0, 0, 4'(8 + i));
      tick(); clr();
    end
    CDBRS_LSB_en = 1; CDBRS_LSB_RoB_index = 4'd7; CDBRS_LSB_value = 32'h77;
    tick(); clr();
    tick();
    chk("pair_first", RSALU_RoB_index, 4'd9);
    tick();
    chk("pair_second", RSALU_RoB_index, 4'd13);
    chk("pair_second_en", RSALU_en, 1'b1);

    // Flush the four waiters; a later matching broadcast must issue nothing.
    RoBRS_pre_judge = 0;
    tick(); clr();
    chk("flush_en", RSALU_en, 1'b0);
    chk("flush_full", RSDP_full, 1'b0);
    chk("flush_rob", RSALU_RoB_index, 4'd0);
    CDBRS_RS_en = 1; CDBRS_RS_RoB_index = 4'd12; CDBRS_RS_value = 32'h12;
    tick(); clr();
    tick();
    chk("flush_stale_1", RSALU_en, 1'b0);
    tick();
    chk("flush_stale_2", RSALU_en, 1'b0);

    // Asynchronous reset while an issue is on the outputs.
    dp(7'd33, 5'd16, 5'd16, 32'h55, 32'h66, 4'd6);
    tick(); clr();
    dp(7'd33, 5'd3, 5'd16, 0, 0, 4'd7);
    tick(); clr();
    chk("pre_reset_en", RSALU_en, 1'b1);
    chk("pre_reset_vj", RSALU_Vj, 32'h55);
    #2;
    Sys_rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_en", RSALU_en, 1'b0);
    chk("async_rst_fields", {RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index}, '0);
    chk("async_rst_full", RSDP_full, 1'b0);
    tick();
    Sys_rst_n = 1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      clr();
      Sys_rdy = ($urandom_range(0, 7) != 0);
      RoBRS_pre_judge = ($urandom_range(0, 63) != 0);
      if (!model_full() && $urandom_range(0, 1) == 1)
        dp(7'($urandom_range(19, 37)),
           ($urandom_range(0, 2) == 0) ? 5'd16 : 5'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0) ? 5'd16 : 5'($urandom_range(0, 7)),
           $urandom, $urandom, 4'($urandom_range(0, 15)));
      CDBRS_RS_en = ($urandom_range(0, 1) == 1);
      CDBRS_RS_RoB_index = 4'($urandom_range(0, 7));
      CDBRS_RS_value = $urandom;
      CDBRS_LSB_en = ($urandom_range(0, 2) == 0);
      CDBRS_LSB_RoB_index = 4'($urandom_range(0, 7));
      CDBRS_LSB_value = $urandom;
      tick();
    end
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
